// File: rtl/rsa_exp_sequencer.sv
// rsa_exp_sequencer: left-to-right binary exponentiation controller.
// Walks the exponent MSB->LSB and hands the Montgomery core one operation
// at a time: to-Montgomery, square, multiply (on set bits) and from-Montgomery.
// Operand movement stays in the core wrapper; this block only decides the
// order of operations and tracks progress.
module rsa_exp_sequencer #(
  parameter int E_WIDTH = 32,
  parameter int IDX_W   = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [E_WIDTH-1:0] exp,
  input  logic [IDX_W-1:0]   exp_len,
  output logic               op_valid,
  output logic [1:0]         op_code,
  input  logic               op_ready,
  input  logic               op_done,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   bit_idx,
  output logic [15:0]        op_count
);

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Phase doubles as the op_code driven to the core
  localparam logic [1:0] PH_TOMONT = 2'd0;
  localparam logic [1:0] PH_SQR    = 2'd1;
  localparam logic [1:0] PH_MUL    = 2'd2;
  localparam logic [1:0] PH_FROM   = 2'd3;

  localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(E_WIDTH);

  logic [1:0]         state_reg,    state_next;
  logic [1:0]         phase_reg,    phase_next;
  logic               op_valid_reg, op_valid_next;
  logic               busy_reg,     busy_next;
  logic               done_reg,     done_next;
  logic [IDX_W-1:0]   bit_idx_reg,  bit_idx_next;
  logic [15:0]        op_count_reg, op_count_next;
  logic [E_WIDTH-1:0] exp_reg,      exp_next;
  logic [IDX_W-1:0]   len_reg,      len_next;

  logic [IDX_W-1:0]   len_clamped;
  logic [E_WIDTH-1:0] exp_keep;
  logic [E_WIDTH-1:0] bit_sel;
  logic               cur_bit;
  logic [1:0]         adv_phase;
  logic [IDX_W-1:0]   adv_idx;
  logic [15:0]        count_inc;

  // Requested length never exceeds the exponent register
  assign len_clamped = (exp_len > LEN_MAX) ? LEN_MAX : exp_len;

  // Bits above the requested length are cleared at capture so they can
  // never influence the square/multiply decision
  generate
    for (genvar gi = 0; gi < E_WIDTH; gi++) begin : g_exp_mask
      assign exp_keep[gi] = exp[gi] & (len_clamped > IDX_W'(gi));
    end
  endgenerate

  // Exponent bit under the scan pointer
  assign bit_sel = {{(E_WIDTH-1){1'b0}}, 1'b1} << bit_idx_reg;
  assign cur_bit = |(exp_reg & bit_sel);

  // Moving to the next lower bit, or finishing after bit 0
  assign adv_phase = (bit_idx_reg == '0) ? PH_FROM : PH_SQR;
  assign adv_idx   = (bit_idx_reg == '0) ? bit_idx_reg : bit_idx_reg - 1'b1;

  // Completed-operation counter sticks at all-ones
  assign count_inc = (op_count_reg == 16'hFFFF) ? op_count_reg : op_count_reg + 16'd1;

  // Next-state and next-output decisions
  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    op_valid_next = op_valid_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;
    bit_idx_next  = bit_idx_reg;
    op_count_next = op_count_reg;
    exp_next      = exp_reg;
    len_next      = len_reg;

    if (abort) begin
      // Abort outranks everything, including a coincident start
      state_next    = ST_IDLE;
      op_valid_next = 1'b0;
      busy_next     = 1'b0;
      done_next     = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            exp_next      = exp_keep;
            len_next      = len_clamped;
            done_next     = 1'b0;
            busy_next     = 1'b1;
            op_count_next = 16'd0;
            phase_next    = PH_TOMONT;
            bit_idx_next  = (len_clamped == '0) ? '0 : len_clamped - 1'b1;
            op_valid_next = 1'b1;
            state_next    = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // op_valid is already high here, so op_ready alone completes
          // the handshake; op_done in this cycle is deliberately ignored
          if (op_ready) begin
            op_valid_next = 1'b0;
            state_next    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (op_done) begin
            op_count_next = count_inc;
            op_valid_next = 1'b1;
            state_next    = ST_ISSUE;
            case (phase_reg)
              PH_TOMONT: phase_next = (len_reg == '0) ? PH_FROM : PH_SQR;
              PH_SQR: begin
                if (cur_bit) begin
                  phase_next = PH_MUL;
                end else begin
                  phase_next   = adv_phase;
                  bit_idx_next = adv_idx;
                end
              end
              PH_MUL: begin
                phase_next   = adv_phase;
                bit_idx_next = adv_idx;
              end
              default: begin
                op_valid_next = 1'b0;
                busy_next     = 1'b0;
                done_next     = 1'b1;
                state_next    = ST_DONE;
              end
            endcase
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= PH_TOMONT;
      op_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bit_idx_reg  <= '0;
      op_count_reg <= 16'd0;
      exp_reg      <= '0;
      len_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      op_valid_reg <= op_valid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      bit_idx_reg  <= bit_idx_next;
      op_count_reg <= op_count_next;
      exp_reg      <= exp_next;
      len_reg      <= len_next;
    end
  end

  assign op_valid = op_valid_reg;
  assign op_code  = phase_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign bit_idx  = bit_idx_reg;
  assign op_count = op_count_reg;

endmodule
